operand_serdes: RTL

Parametrised byte-serial front end for the arithmetic core: loads N_OPS operands of WIDTH bits over an 8-bit input bus, launches the core, captures its result and streams it back out over an 8-bit output bus. Operand count, operand width and a partial top byte are all parameterised. Input and output use explicit valid/ready handshakes. A synchronous flush lets the host abort a transaction. The block sits between the chip's byte-wide pads and the compute datapath.

---
 rtl/operand_serdes_pkg.sv | 19 +
 rtl/operand_serdes_byte_slicer.sv | 31 +++
 rtl/operand_serdes.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/operand_serdes_pkg.sv
// rtl/operand_serdes_pkg.sv - shared types, constants and helpers for operand_serdes
//   state_t   : transaction phase (LOAD, CALC, UNLOAD)
//   BUS_W     : width of the byte-wide pad buses
//   bytes_for : number of bus bytes needed to carry a word of the given width
package operand_serdes_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CALC   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  function automatic int bytes_for(input int width);
    return (width + BUS_W - 1) / BUS_W;
  endfunction

endpackage

// File: rtl/operand_serdes_byte_slicer.sv
// rtl/operand_serdes_byte_slicer.sv - MSB-first byte selector for a WIDTH-bit word
//   word_i : word to slice
//   idx_i  : byte index, 0 = least significant byte
//   byte_o : selected byte; the top byte is zero-extended when WIDTH is not a byte multiple
module byte_slicer
  import operand_serdes_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [BUS_W-1:0] byte_o
);

  localparam int BYTES = bytes_for(WIDTH);

  logic [BYTES*BUS_W-1:0] padded;

  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = word_i;
    byte_o = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (idx_i == IDX_W'(b)) begin
        byte_o = padded[b*BUS_W +: BUS_W];
      end
    end
  end

endmodule

// File: rtl/operand_serdes.sv
// rtl/operand_serdes.sv - byte-serial operand loader / result unloader for the arithmetic core
//   clk, reset       : clock, asynchronous active-low reset
//   flush            : synchronous abort back to LOAD
//   in_data/in_valid/in_ready     : operand byte stream in, MSB-first per operand
//   operands         : N_OPS packed operands, driven only in CALC
//   calc_start       : one-cycle launch pulse to the core
//   calc_done/result : core completion and result
//   out_data/out_valid/out_ready  : result byte stream out, MSB-first
//   busy             : high in CALC and UNLOAD
module operand_serdes
  import operand_serdes_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int N_OPS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [BUS_W-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OPS*WIDTH-1:0] operands,
  output logic                   calc_start,
  input  logic                   calc_done,
  input  logic [WIDTH-1:0]       result,
  output logic [BUS_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int BYTES    = bytes_for(WIDTH);
  localparam int BIDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int OIDX_W   = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  // Number of meaningful bits in the most significant (possibly partial) byte.
  localparam int TOP_BITS = WIDTH - BUS_W * (BYTES - 1);
  localparam logic [BIDX_W-1:0] TOP_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [OIDX_W-1:0] LAST_OP  = OIDX_W'(N_OPS - 1);

  state_t            state_q;
  logic [OIDX_W-1:0] op_idx_q;
  logic [BIDX_W-1:0] byte_idx_q;
  logic [BIDX_W-1:0] out_idx_q;
  logic [WIDTH-1:0]  ops_q [N_OPS];
  logic [WIDTH-1:0]  shadow_q;
  logic              calc_start_q;
  logic [BUS_W-1:0]  slice_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD;
      op_idx_q     <= '0;
      byte_idx_q   <= TOP_BYTE;
      out_idx_q    <= TOP_BYTE;
      shadow_q     <= '0;
      calc_start_q <= 1'b0;
      for (int k = 0; k < N_OPS; k++) ops_q[k] <= '0;
    end else if (flush) begin
      // Abort wins over any handshake in the same cycle; that byte is dropped.
      state_q      <= LOAD;
      op_idx_q     <= '0;
      byte_idx_q   <= TOP_BYTE;
      out_idx_q    <= TOP_BYTE;
      shadow_q     <= '0;
      calc_start_q <= 1'b0;
      for (int k = 0; k < N_OPS; k++) ops_q[k] <= '0;
    end else begin
      calc_start_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            for (int k = 0; k < N_OPS; k++) begin
              if (op_idx_q == OIDX_W'(k)) begin
                // Top byte keeps only its low TOP_BITS bits; the rest of in_data is ignored.
                if (byte_idx_q == TOP_BYTE) begin
                  ops_q[k][WIDTH-1 -: TOP_BITS] <= in_data[TOP_BITS-1:0];
                end
                for (int b = 0; b < BYTES - 1; b++) begin
                  if (byte_idx_q == BIDX_W'(b)) begin
                    ops_q[k][b*BUS_W +: BUS_W] <= in_data;
                  end
                end
              end
            end
            if (byte_idx_q == '0) begin
              byte_idx_q <= TOP_BYTE;
              if (op_idx_q == LAST_OP) begin
                op_idx_q     <= '0;
                state_q      <= CALC;
                calc_start_q <= 1'b1;
              end else begin
                op_idx_q <= op_idx_q + 1'b1;
              end
            end else begin
              byte_idx_q <= byte_idx_q - 1'b1;
            end
          end
        end
        CALC: begin
          // Also honoured in the calc_start cycle (zero-latency core).
          if (calc_done) begin
            shadow_q  <= result;
            out_idx_q <= TOP_BYTE;
            state_q   <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (out_idx_q == '0) begin
              state_q    <= LOAD;
              out_idx_q  <= TOP_BYTE;
              op_idx_q   <= '0;
              byte_idx_q <= TOP_BYTE;
              for (int k = 0; k < N_OPS; k++) ops_q[k] <= '0;
            end else begin
              out_idx_q <= out_idx_q - 1'b1;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  byte_slicer #(
    .WIDTH (WIDTH),
    .IDX_W (BIDX_W)
  ) u_slicer (
    .word_i (shadow_q),
    .idx_i  (out_idx_q),
    .byte_o (slice_byte)
  );

  // Every output is decoded from registered state only.
  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (state_q == UNLOAD);
  assign busy       = (state_q != LOAD);
  assign calc_start = calc_start_q;
  assign out_data   = (state_q == UNLOAD) ? slice_byte : '0;

  always_comb begin
    operands = '0;
    if (state_q == CALC) begin
      for (int k = 0; k < N_OPS; k++) begin
        operands[k*WIDTH +: WIDTH] = ops_q[k];
      end
    end
  end

endmodule
